// File: rtl/mod_n_updown_counter_if.sv
// Interface bundling the control inputs and status outputs of the modulo-N
// up/down counter. The master side drives control; the counter is the slave.
// W sets the count/load width and WW the wrap-counter width; both must match
// the parameters of the counter instance attached to it.
interface mod_n_updown_counter_if #(
    parameter int W  = 4,
    parameter int WW = 8
);
    logic          en;
    logic          up;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  count;
    logic          tc;
    logic          load_err;
    logic [WW-1:0] wraps;

    // Controller side: issues enable/direction/load, observes count and status
    modport master (
        output en, up, load, load_val,
        input  count, tc, load_err, wraps
    );

    // Counter side: consumes control, produces count and status
    modport slave (
        input  en, up, load, load_val,
        output count, tc, load_err, wraps
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with count enable, direction,
// synchronous range-checked load and a zero-latency terminal-count output
// for cascading digit stages (stage k+1 en tied to stage k tc).
// Optional feature: define MODN_CNT_WRAPS_EN to build a saturating wrap
// counter that increments on every edge where tc is high; when undefined
// the wraps output is tied to zero and no register is built.
module mod_n_updown_counter #(
    parameter int N  = 10,
    parameter int W  = 4,
    parameter int WW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mod_n_updown_counter_if.slave   bus
);

    // Highest legal count; for N == 2**W this is the all-ones value
    localparam logic [W-1:0] MAX_VAL = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         load_err_q;
    logic         load_err_d;
    logic         at_terminal;
    logic         tc;

    // Terminal detection depends on the direction currently requested, so a
    // direction change is reflected immediately in tc without any extra state
    always_comb begin
        at_terminal = 1'b0;
        tc          = 1'b0;
        if (bus.up) begin
            at_terminal = (count_q == MAX_VAL);
        end else begin
            at_terminal = (count_q == '0);
        end
        tc = bus.en & ~bus.load & at_terminal;
    end

    // Next count: load wins over counting; out-of-range loads fall back to 0
    // so the count can never leave 0..N-1
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (bus.load_val <= MAX_VAL) begin
                count_d = bus.load_val;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                count_d = (count_q == MAX_VAL) ? '0 : count_q + W'(1);
            end else begin
                count_d = (count_q == '0) ? MAX_VAL : count_q - W'(1);
            end
        end
    end

    // Count and load-error registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = tc;

`ifdef MODN_CNT_WRAPS_EN
    logic [WW-1:0] wraps_q;
    logic [WW-1:0] wraps_d;

    // Wrap count advances on each terminal-count edge and sticks at all-ones
    // rather than rolling over; only reset clears it
    always_comb begin
        wraps_d = wraps_q;
        if (tc && (wraps_q != {WW{1'b1}})) begin
            wraps_d = wraps_q + WW'(1);
        end
    end

    // Wrap-count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign bus.wraps = wraps_q;
`else
    assign bus.wraps = WW'(0);
`endif

endmodule
